// File: rtl/ppm_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ppm_frame_scheduler
//  Purpose  : Round-robin arbiter and frame sequencer feeding one PPM encoder
//             from a beacon channel (ch0) and a user-data channel (ch1).
//  Revision : 1.0
// ============================================================================
module ppm_frame_scheduler #(
   parameter int SLOT_CYCLES = 1,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic [7:0] dat0,
   input  logic [7:0] dat1,
   input  logic       dval0,
   input  logic       dval1,
   output logic       drdy0,
   output logic       drdy1,
   output logic       grant0,
   output logic       grant1,
   output logic       Le,
   output logic [3:0] N,
   output logic [7:0] Din,
   output logic       busy,
   output logic       underrun
);

   localparam int c_SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int c_GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(SLOT_CYCLES - 1);
   localparam logic [c_GW-1:0] c_GAP_LAST  = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t          r_state, w_state;
   logic            r_sel, w_sel;
   logic            r_prio, w_prio;     // 1: ch1 wins a tie
   logic [3:0]      r_len, w_len;
   logic [3:0]      r_bcnt, w_bcnt;
   logic [c_SW-1:0] r_scnt, w_scnt;
   logic [c_GW-1:0] r_gcnt, w_gcnt;
   logic            w_le, w_grant0, w_grant1, w_busy, w_underrun, w_fetch;
   logic [3:0]      w_n;
   logic [7:0]      w_din;

   logic       w_el0, w_el1, w_pick, w_dval_sel;
   logic [7:0] w_dat_sel;

   assign w_el0      = req0 & (len0 != 4'd0);
   assign w_el1      = req1 & (len1 != 4'd0);
   assign w_pick     = w_el1 & (~w_el0 | r_prio);
   assign w_dat_sel  = r_sel ? dat1 : dat0;
   assign w_dval_sel = r_sel ? dval1 : dval0;

   // A fetch point is the HDR cycle or the last cycle of a non-final slot.
   assign drdy0 = w_fetch & ~r_sel;
   assign drdy1 = w_fetch & r_sel;

   always_comb begin
      w_state    = r_state;
      w_sel      = r_sel;
      w_prio     = r_prio;
      w_len      = r_len;
      w_bcnt     = r_bcnt;
      w_scnt     = r_scnt;
      w_gcnt     = r_gcnt;
      w_le       = 1'b0;
      w_n        = 4'd0;
      w_din      = Din;
      w_grant0   = 1'b0;
      w_grant1   = 1'b0;
      w_busy     = busy;
      w_underrun = 1'b0;
      w_fetch    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_din = 8'h00;
            if (w_el0 || w_el1) begin
               w_sel    = w_pick;
               w_prio   = ~w_pick;
               w_len    = w_pick ? len1 : len0;
               w_le     = 1'b1;
               w_n      = w_pick ? len1 : len0;
               w_din    = 8'h00;
               w_grant0 = ~w_pick;
               w_grant1 = w_pick;
               w_busy   = 1'b1;
               w_state  = S_HDR;
            end
         end
         S_HDR: begin
            w_fetch = 1'b1;
            w_bcnt  = 4'd1;
            w_scnt  = '0;
            w_state = S_DATA;
         end
         S_DATA: begin
            if (r_scnt == c_SLOT_LAST) begin
               if (r_bcnt < r_len) begin
                  w_fetch = 1'b1;
                  w_bcnt  = r_bcnt + 4'd1;
                  w_scnt  = '0;
               end else begin
                  w_din  = 8'h00;
                  w_gcnt = '0;
                  if (GAP_CYCLES == 0) begin
                     w_state = S_IDLE;
                     w_busy  = 1'b0;
                  end else begin
                     w_state = S_GAP;
                  end
               end
            end else begin
               w_scnt = r_scnt + c_SW'(1);
            end
         end
         S_GAP: begin
            if (r_gcnt == c_GAP_LAST) begin
               w_state = S_IDLE;
               w_busy  = 1'b0;
            end else begin
               w_gcnt = r_gcnt + c_GW'(1);
            end
         end
         default: w_state = S_IDLE;
      endcase
      // Missing byte at a fetch point is replaced by 0x00 and flagged.
      if (w_fetch) begin
         w_din      = w_dval_sel ? w_dat_sel : 8'h00;
         w_underrun = ~w_dval_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sel    <= 1'b0;
         r_prio   <= 1'b0;
         r_len    <= 4'd0;
         r_bcnt   <= 4'd0;
         r_scnt   <= '0;
         r_gcnt   <= '0;
         Le       <= 1'b0;
         N        <= 4'd0;
         Din      <= 8'h00;
         grant0   <= 1'b0;
         grant1   <= 1'b0;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_sel    <= w_sel;
         r_prio   <= w_prio;
         r_len    <= w_len;
         r_bcnt   <= w_bcnt;
         r_scnt   <= w_scnt;
         r_gcnt   <= w_gcnt;
         Le       <= w_le;
         N        <= w_n;
         Din      <= w_din;
         grant0   <= w_grant0;
         grant1   <= w_grant1;
         busy     <= w_busy;
         underrun <= w_underrun;
      end
   end

endmodule
`default_nettype wire
